// File: rtl/iob_split_ordered_pkg.sv
// Shared IOb-native interconnect layout: packed request/response widths and field offsets.
// Request slice  = {valid, addr, wdata, wstrb} (MSB..LSB); response slice = {rdata, rvalid, ready}.
// Used by both the master merge and the ordered split so the two agree on bit positions.
package iob_split_ordered_pkg;

  // Response field offsets within one RESP_W slice
  localparam int RESP_READY  = 0;
  localparam int RESP_RVALID = 1;
  localparam int RESP_RDATA  = 2;

  // Request field offsets within one REQ_W slice
  localparam int REQ_WSTRB_LSB = 0;

  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int req_wdata_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw / 8 + dw;
  endfunction

  function automatic int req_valid_bit(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/iob_split_ordered_err_slave.sv
// Error target: absorbs unmapped accesses, returns an empty read response and flags the error.
// Latency: rvalid and err pulse one cycle after the accept; always ready, never backpressures.
// Ports: clk_i/rst_i, acc_i (accepted ERR access), rd_i (access is a read), rvalid_o, err_o.
module iob_split_ordered_err_slave (
  input  logic clk_i,
  input  logic rst_i,
  input  logic acc_i,
  input  logic rd_i,
  output logic rvalid_o,
  output logic err_o
);

  // rvalid_o is the err_pend state: set by an accepted read, self-clears next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= acc_i & rd_i;
      err_o    <= acc_i;
    end
  end

endmodule

// File: rtl/iob_split_ordered.sv
// Ordered 1-to-N IOb split: steers requests by top address bits, returns read data in order.
// Latency: request path combinational (0 cycles); response path combinational from the owner.
// Backpressure: stalls while reads are pending to a different target or MAX_OUTST are in flight.
// Ports: clk_i/rst_i; m_req_i/m_resp_o upstream; s_req_o/s_resp_i per-slave slices (slave k = field k);
//        busy_o reads outstanding; err_o one-cycle pulse on unmapped access or spurious rvalid.
module iob_split_ordered
  import iob_split_ordered_pkg::*;
#(
  parameter int N_SLAVES  = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 4,
  localparam int REQ_W    = req_w(ADDR_W, DATA_W),
  localparam int RESP_W   = resp_w(DATA_W)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REQ_W-1:0]           m_req_i,
  output logic [RESP_W-1:0]          m_resp_o,
  output logic [N_SLAVES*REQ_W-1:0]  s_req_o,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int NB = $clog2(N_SLAVES);
  localparam int OW = $clog2(N_SLAVES + 1);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = DATA_W / 8;
  localparam int VB = req_valid_bit(ADDR_W, DATA_W);
  localparam logic [OW-1:0] ERR_IDX = OW'(N_SLAVES);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

  logic [OW-1:0] owner;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          spur_q;

  logic                m_vld, is_rd;
  logic [NB-1:0]       addr_tgt;
  logic [OW-1:0]       tgt;
  logic [N_SLAVES-1:0] s_rdy, s_rvld, own_sel;
  logic [DATA_W-1:0]   s_rdata [N_SLAVES];
  logic                own_rvld, tgt_rdy, err_rvld, err_pulse;
  logic [DATA_W-1:0]   own_rdata;
  logic                stall, m_rdy, accept, rd_acc, rsp_v, spurious;

  assign m_vld    = m_req_i[VB];
  assign is_rd    = (m_req_i[REQ_WSTRB_LSB +: SW] == '0);
  assign addr_tgt = m_req_i[VB-1 -: NB];
  // Address codes beyond the last slave fold onto the virtual error target
  assign tgt      = (OW'(addr_tgt) >= ERR_IDX) ? ERR_IDX : OW'(addr_tgt);

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_unpack
    assign s_rdy[k]   = s_resp_i[k*RESP_W + RESP_READY];
    assign s_rvld[k]  = s_resp_i[k*RESP_W + RESP_RVALID];
    assign s_rdata[k] = s_resp_i[k*RESP_W + RESP_RDATA +: DATA_W];
    assign own_sel[k] = (owner == OW'(k));
  end

  always_comb begin
    own_rvld  = err_rvld;
    own_rdata = '0;
    tgt_rdy   = 1'b1;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (own_sel[k]) begin
        own_rvld  = s_rvld[k];
        own_rdata = s_rdata[k];
      end
      if (tgt == OW'(k)) tgt_rdy = s_rdy[k];
    end
  end

  // A response from the owner in the same cycle frees a slot at the cap
  assign stall    = m_vld & (((cnt != '0) & (tgt != owner)) |
                             ((cnt == CNT_MAX) & ~own_rvld));
  assign m_rdy    = ~stall & tgt_rdy;
  assign accept   = m_vld & m_rdy;
  assign rd_acc   = accept & is_rd;
  assign rsp_v    = own_rvld & (cnt != '0);
  assign spurious = (|(s_rvld & ~own_sel)) | (own_rvld & (cnt == '0));

  always_comb begin
    s_req_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (tgt == OW'(k)) begin
        s_req_o[k*REQ_W +: REQ_W] = m_req_i;
        s_req_o[k*REQ_W + VB]     = m_vld & ~stall;
      end
    end
  end

  assign m_resp_o = {own_rdata, rsp_v, m_rdy};

  always_comb begin
    case ({rd_acc, rsp_v})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      owner  <= '0;
      busy_o <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy_o <= (cnt_nxt != '0);
      spur_q <= spurious;
      if (rd_acc) owner <= tgt;
    end
  end

  iob_split_ordered_err_slave u_err (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .acc_i    (accept & (tgt == ERR_IDX)),
    .rd_i     (is_rd),
    .rvalid_o (err_rvld),
    .err_o    (err_pulse)
  );

  assign err_o = err_pulse | spur_q;

endmodule

// File: tb/tb_iob_split_ordered.sv
// Bench for iob_split_ordered with three slaves (top code 3 is unmapped) and MAX_OUTST=4.
// Reference model: an in-order queue of outstanding read targets plus the last read target.
module tb_iob_split_ordered;

  localparam int NS = 3;
  localparam int MAXO = 4;
  localparam int RQ = 69;
  localparam int RS = 34;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [RQ-1:0]    m_req_i;
  logic [RS-1:0]    m_resp_o;
  logic [NS*RQ-1:0] s_req_o;
  logic [NS*RS-1:0] s_resp_i;
  logic busy_o, err_o;

  iob_split_ordered #(.N_SLAVES(NS), .DATA_W(32), .ADDR_W(32), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_req_i(m_req_i), .m_resp_o(m_resp_o),
    .s_req_o(s_req_o), .s_resp_i(s_resp_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // driven stimulus
  logic        v;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic [NS-1:0] s_rdy, s_rv;
  logic [31:0] s_rd [NS];

  // reference model
  int q[$];
  int owner_m;
  bit err_due;
  bit exp_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [RQ-1:0] obs, input logic [RQ-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m_req_i = {v, addr, wdata, strb};
    for (int k = 0; k < NS; k++) s_resp_i[k*RS +: RS] = {s_rd[k], s_rv[k], s_rdy[k]};
  endtask

  task automatic set_req(input logic vv, input logic [31:0] a, input logic [3:0] s);
    v = vv; addr = a; strb = s; wdata = $urandom;
  endtask

  // One clock: check combinational outputs against the model, clock, then registered outputs
  task automatic cycle();
    int tgt, n;
    bit rsp, blocked, er, ac, sp;
    logic [31:0] od;
    apply();
    #1;
    tgt = int'(addr[31:30]);
    n   = q.size();
    rsp = 1'b0;
    od  = '0;
    if (owner_m == NS) rsp = err_due;
    else begin
      rsp = s_rv[owner_m];
      od  = s_rd[owner_m];
    end
    blocked = v && ((n > 0 && tgt != owner_m) || (n == MAXO && !rsp));
    er = !blocked && ((tgt == NS) ? 1'b1 : s_rdy[tgt]);
    ac = v && er;
    chk("ready", RQ'(m_resp_o[0]), RQ'(er));
    chk("rvalid", RQ'(m_resp_o[1]), RQ'(rsp && n > 0));
    if (rsp && n > 0) chk("rdata", RQ'(m_resp_o[33:2]), RQ'(od));
    for (int k = 0; k < NS; k++) begin
      if (k == tgt) chk("s_req_tgt", s_req_o[k*RQ +: RQ], {v && !blocked, addr, wdata, strb});
      else          chk("s_req_idle", s_req_o[k*RQ +: RQ], '0);
    end
    sp = 1'b0;
    for (int k = 0; k < NS; k++) if (s_rv[k] && k != owner_m) sp = 1'b1;
    if (rsp && n == 0) sp = 1'b1;
    @(posedge clk_i);
    if (rsp && n > 0) void'(q.pop_front());
    if (ac && strb == 4'h0) begin
      q.push_back(tgt);
      owner_m = tgt;
    end
    err_due = ac && strb == 4'h0 && tgt == NS;
    exp_err = (ac && tgt == NS) || sp;
    #1;
    chk("busy", RQ'(busy_o), RQ'(q.size() != 0));
    chk("err", RQ'(err_o), RQ'(exp_err));
  endtask

  task automatic do_reset();
    v = 1'b0; s_rv = '0; rst_i = 1'b1;
    apply();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    q.delete(); owner_m = 0; err_due = 1'b0;
    chk("rst_busy", RQ'(busy_o), '0);
    chk("rst_err", RQ'(err_o), '0);
    chk("rst_rvalid", RQ'(m_resp_o[1]), '0);
  endtask

  initial begin
    rst_i = 1'b0; v = 1'b0; addr = '0; wdata = '0; strb = '0;
    s_rdy = '1; s_rv = '0;
    for (int k = 0; k < NS; k++) s_rd[k] = '0;
    owner_m = 0; err_due = 1'b0; exp_err = 1'b0;
    apply();
    do_reset();

    // Single read to slave 0, response two cycles after accept
    set_req(1'b1, 32'h0000_0010, 4'h0); cycle();
    v = 1'b0; cycle();
    s_rv[0] = 1'b1; s_rd[0] = 32'hCAFE_0001; apply(); #1;
    chk("t1_rdata", RQ'(m_resp_o[33:2]), RQ'(32'hCAFE_0001));
    chk("t1_rvalid", RQ'(m_resp_o[1]), RQ'(1'b1));
    cycle();
    s_rv = '0; cycle();
    chk("t1_busy", RQ'(busy_o), '0);

    // Fill to the cap, then a same-cycle response lets the fifth read in
    for (int i = 0; i < MAXO; i++) begin set_req(1'b1, 32'h0000_0020, 4'h0); cycle(); end
    apply(); #1;
    chk("t2_cap_ready", RQ'(m_resp_o[0]), '0);
    cycle();
    s_rv[0] = 1'b1; s_rd[0] = $urandom; apply(); #1;
    chk("t2_unblock_ready", RQ'(m_resp_o[0]), RQ'(1'b1));
    cycle();
    chk("t2_busy_held", RQ'(busy_o), RQ'(1'b1));
    v = 1'b0;
    for (int i = 0; i < MAXO; i++) begin s_rd[0] = $urandom; cycle(); end
    s_rv = '0; cycle();
    chk("t2_drained", RQ'(busy_o), '0);

    // Switching target waits for the pending read to complete
    set_req(1'b1, 32'h0000_0000, 4'h0); cycle();
    set_req(1'b1, 32'h8000_0000, 4'h0); apply(); #1;
    chk("t3_s2_vld", RQ'(s_req_o[2*RQ + RQ-1]), '0);
    chk("t3_ready", RQ'(m_resp_o[0]), '0);
    cycle();
    s_rv[0] = 1'b1; apply(); #1;
    chk("t3_ready_rsp", RQ'(m_resp_o[0]), '0);
    cycle();
    s_rv = '0; apply(); #1;
    chk("t3_ready_after", RQ'(m_resp_o[0]), RQ'(1'b1));
    cycle();
    v = 1'b0; s_rv[2] = 1'b1; s_rd[2] = 32'h1234_5678; cycle();
    s_rv = '0; cycle();

    // Writes: other target stalls behind a pending read, same target passes
    set_req(1'b1, 32'h0000_0008, 4'h0); cycle();
    set_req(1'b1, 32'h8000_0004, 4'hF); apply(); #1;
    chk("t4_wr_other", RQ'(m_resp_o[0]), '0);
    cycle();
    set_req(1'b1, 32'h0000_0004, 4'hF); apply(); #1;
    chk("t4_wr_same", RQ'(m_resp_o[0]), RQ'(1'b1));
    cycle();
    chk("t4_busy", RQ'(busy_o), RQ'(1'b1));
    v = 1'b0; s_rv[0] = 1'b1; cycle();
    s_rv = '0; cycle();

    // Unmapped read
    set_req(1'b1, 32'hC000_0000, 4'h0); apply(); #1;
    chk("t5_ready", RQ'(m_resp_o[0]), RQ'(1'b1));
    chk("t5_no_vld", RQ'({s_req_o[2*RQ+RQ-1], s_req_o[RQ+RQ-1], s_req_o[RQ-1]}), '0);
    cycle();
    chk("t5_err", RQ'(err_o), RQ'(1'b1));
    v = 1'b0; apply(); #1;
    chk("t5_rvalid", RQ'(m_resp_o[1]), RQ'(1'b1));
    chk("t5_rdata", RQ'(m_resp_o[33:2]), '0);
    cycle();
    cycle();

    // Reset with reads in flight, then a late response
    set_req(1'b1, 32'h0000_0000, 4'h0); cycle(); cycle();
    v = 1'b0; cycle();
    do_reset();
    s_rv[0] = 1'b1; apply(); #1;
    chk("t6_late_rvalid", RQ'(m_resp_o[1]), '0);
    cycle();
    chk("t6_late_err", RQ'(err_o), RQ'(1'b1));
    s_rv = '0; cycle();

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      v     = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      strb  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0;
      s_rdy = NS'($urandom);
      s_rv  = '0;
      for (int k = 0; k < NS; k++) s_rd[k] = $urandom;
      if (q.size() != 0 && owner_m < NS && $urandom_range(0, 1) == 1) s_rv[owner_m] = 1'b1;
      if ($urandom_range(0, 19) == 0) s_rv[$urandom_range(0, NS-1)] = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
